// File: rtl/bus2st_pkt.sv
// Bus-to-stream packetiser: unpacks wide bus words into a framed sample stream
// and meters packet starts against a decoder credit counter.
module bus2st_pkt #(
   parameter int BUS_W   = 512,
   parameter int ST_W    = 12,
   parameter int NUM_ST  = 42,
   parameter int LEN_W   = 13,
   parameter int MAX_OUT = 2,
   parameter int CW      = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [LEN_W-1:0] cfg_pkt_len,
   input  logic [BUS_W-1:0] bus_data,
   input  logic             bus_en,
   output logic             bus_ready,
   output logic [ST_W-1:0]  st_data,
   output logic             st_valid,
   input  logic             st_ready,
   output logic             st_sop,
   output logic             st_eop,
   input  logic             dec_done,
   output logic [CW-1:0]    credits,
   output logic             err_credit
);

   localparam int IDX_W = (NUM_ST > 1) ? $clog2(NUM_ST) : 1;
   localparam int OFF_W = (BUS_W > 1) ? $clog2(BUS_W) : 1;
   localparam logic [CW-1:0] MAX_CRED = CW'(MAX_OUT);

   typedef enum logic {IDLE, STREAM} state_t;

   state_t            state_q, state_d;
   logic [BUS_W-1:0]  mem_q [2];
   logic              wrPtr_q, wrPtr_d;
   logic              rdPtr_q, rdPtr_d;
   logic [1:0]        occ_q, occ_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [CW-1:0]     cred_q, cred_d;
   logic              err_q, err_d;

   logic              push, pop, start, handshake, lastInWord;
   logic [BUS_W-1:0]  headWord;
   logic [OFF_W-1:0]  sampleOff;
   logic [LEN_W-1:0]  lenM1;

   // State register; the buffer payload itself needs no reset since occupancy guards it
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         wrPtr_q <= 1'b0;
         rdPtr_q <= 1'b0;
         occ_q   <= 2'd0;
         idx_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         cred_q  <= MAX_CRED;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         occ_q   <= occ_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         cred_q  <= cred_d;
         err_q   <= err_d;
      end
      if (push) begin
         mem_q[wrPtr_q] <= bus_data;
      end
   end

   always_comb begin
      push       = bus_en && bus_ready;
      handshake  = st_valid && st_ready;
      lastInWord = (idx_q == IDX_W'(NUM_ST - 1));
      start      = (state_q == IDLE) && (cred_q != '0) && (occ_q != 2'd0);
      pop        = handshake && (st_eop || lastInWord);

      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      wrPtr_d = wrPtr_q ^ push;
      rdPtr_d = rdPtr_q ^ pop;

      occ_d = occ_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + 2'd1;
         2'b01:   occ_d = occ_q - 2'd1;
         default: occ_d = occ_q;
      endcase

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = STREAM;
               len_d   = (cfg_pkt_len == '0) ? LEN_W'(1) : cfg_pkt_len;
               idx_d   = '0;
               cnt_d   = '0;
            end
         end
         STREAM: begin
            // A finished packet discards the rest of its last word
            if (handshake) begin
               cnt_d = cnt_q + LEN_W'(1);
               if (st_eop) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else if (lastInWord) begin
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      cred_d = cred_q;
      err_d  = err_q;
      case ({start, dec_done})
         2'b10: cred_d = cred_q - CW'(1);
         2'b01: begin
            if (cred_q == MAX_CRED) begin
               err_d = 1'b1;
            end else begin
               cred_d = cred_q + CW'(1);
            end
         end
         default: cred_d = cred_q;
      endcase
   end

   always_comb begin
      headWord   = mem_q[rdPtr_q];
      sampleOff  = OFF_W'(idx_q * ST_W);
      lenM1      = len_q - LEN_W'(1);
      st_valid   = (state_q == STREAM) && (occ_q != 2'd0);
      st_data    = st_valid ? headWord[sampleOff +: ST_W] : '0;
      st_sop     = st_valid && (cnt_q == '0);
      st_eop     = st_valid && (cnt_q == lenM1);
      bus_ready  = !rst && (occ_q < 2'd2);
      credits    = cred_q;
      err_credit = err_q;
   end

endmodule

// File: tb/tb_bus2st_pkt.sv
// Bench for bus2st_pkt: random bus/sink timing against a sample-queue reference
// model plus a few literal checks on packet framing, credits and reset.
module tb_bus2st_pkt;

   localparam int BUS_W   = 512;
   localparam int ST_W    = 12;
   localparam int NUM_ST  = 42;
   localparam int LEN_W   = 13;
   localparam int MAX_OUT = 2;
   localparam int CW      = 3;

   logic             clk;
   logic             rst;
   logic [LEN_W-1:0] cfg_pkt_len;
   logic [BUS_W-1:0] bus_data;
   logic             bus_en;
   logic             bus_ready;
   logic [ST_W-1:0]  st_data;
   logic             st_valid;
   logic             st_ready;
   logic             st_sop;
   logic             st_eop;
   logic             dec_done;
   logic [CW-1:0]    credits;
   logic             err_credit;

   bus2st_pkt #(
      .BUS_W(BUS_W), .ST_W(ST_W), .NUM_ST(NUM_ST),
      .LEN_W(LEN_W), .MAX_OUT(MAX_OUT), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .cfg_pkt_len(cfg_pkt_len),
      .bus_data(bus_data), .bus_en(bus_en), .bus_ready(bus_ready),
      .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready),
      .st_sop(st_sop), .st_eop(st_eop), .dec_done(dec_done),
      .credits(credits), .err_credit(err_credit)
   );

   typedef struct {
      logic [ST_W-1:0] data;
      bit              sop;
      bit              eop;
      bit              popw;
   } samp_t;

   samp_t            expQ[$];
   logic [BUS_W-1:0] wordQ[$];

   int total = 0;
   int bad   = 0;
   int readyPct = 100;
   int gapPct   = 0;

   int              mOcc;
   int              mCred;
   bit              mErr;
   bit              prevStall, decPrev, prevSop, prevEop;
   logic [ST_W-1:0] prevData;
   bit              newPkt, popW, pushW;

   int              pktSamples, lastPktSamples, wordsAccepted;
   logic [ST_W-1:0] firstSopData, lastEopData;
   bit              lastSopEop, sawFull;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic noteTimeout(input string name);
      total++;
      bad++;
      $display("[TB] FAIL %s: timed out at %0t", name, $time);
   endtask

   // Queue nPkts packets: bus words for the driver plus the samples the sink must see
   task automatic applyStimulus(input int len, input int nPkts, input bit seqPattern);
      int eff;
      int nw;
      logic [BUS_W-1:0] word;
      logic [ST_W-1:0]  s;
      samp_t e;
      eff = (len == 0) ? 1 : len;
      nw  = (eff + NUM_ST - 1) / NUM_ST;
      for (int p = 0; p < nPkts; p++) begin
         for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < BUS_W / 32; k++) word[k*32 +: 32] = $urandom;
            for (int j = 0; j < NUM_ST; j++) begin
               s = seqPattern ? ST_W'((w * NUM_ST + j) % 4096) : ST_W'($urandom);
               word[j*ST_W +: ST_W] = s;
               if (w * NUM_ST + j < eff) begin
                  e.data = s;
                  e.sop  = (w * NUM_ST + j == 0);
                  e.eop  = (w * NUM_ST + j == eff - 1);
                  e.popw = e.eop || (j == NUM_ST - 1);
                  expQ.push_back(e);
               end
            end
            wordQ.push_back(word);
         end
      end
   endtask

   task automatic waitDrain(input int budget);
      int n = 0;
      while ((expQ.size() > 0 || wordQ.size() > 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) noteTimeout("drain");
      repeat (3) @(negedge clk);
   endtask

   task automatic pulseDone();
      @(posedge clk); #1 dec_done = 1'b1;
      @(posedge clk); #1 dec_done = 1'b0;
   endtask

   task automatic returnCredits();
      for (int i = 0; i < 10 && credits < CW'(MAX_OUT); i++) pulseDone();
   endtask

   // Bus source and sink: random gaps on bus_en, random st_ready
   initial begin
      bus_en   = 1'b0;
      bus_data = '0;
      st_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst && wordQ.size() > 0 && $urandom_range(99) >= gapPct) begin
            bus_en   = 1'b1;
            bus_data = wordQ[0];
         end else begin
            bus_en = 1'b0;
         end
         st_ready = ($urandom_range(99) < readyPct);
      end
   end

   // Reference model and per-cycle compare
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("bus_ready_in_reset", {63'd0, bus_ready}, 64'd0);
         expQ.delete();
         wordQ.delete();
         mOcc      = 0;
         mCred     = MAX_OUT;
         mErr      = 1'b0;
         prevStall = 1'b0;
         decPrev   = 1'b0;
         pktSamples = 0;
      end else begin
         if (prevStall) begin
            checkOutput("hold_valid", {63'd0, st_valid}, 64'd1);
            checkOutput("hold_data", {52'd0, st_data}, {52'd0, prevData});
            checkOutput("hold_sop", {63'd0, st_sop}, {63'd0, prevSop});
            checkOutput("hold_eop", {63'd0, st_eop}, {63'd0, prevEop});
         end
         newPkt = st_valid && st_sop && !prevStall;
         if (decPrev && !newPkt && mCred == MAX_OUT) begin
            mErr = 1'b1;
         end else begin
            mCred = mCred - int'(newPkt) + int'(decPrev);
         end
         checkOutput("credits", {61'd0, credits}, 64'(mCred));
         checkOutput("err_credit", {63'd0, err_credit}, {63'd0, mErr});
         checkOutput("bus_ready", {63'd0, bus_ready}, {63'd0, mOcc < 2});
         popW = 1'b0;
         if (st_valid) begin
            if (expQ.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_sample: got data %0h expected no sample at %0t", st_data, $time);
            end else begin
               checkOutput("st_data", {52'd0, st_data}, {52'd0, expQ[0].data});
               checkOutput("st_sop", {63'd0, st_sop}, {63'd0, expQ[0].sop});
               checkOutput("st_eop", {63'd0, st_eop}, {63'd0, expQ[0].eop});
               if (st_ready) begin
                  popW = expQ[0].popw;
                  if (st_sop) begin
                     pktSamples   = 0;
                     firstSopData = st_data;
                  end
                  pktSamples++;
                  if (st_eop) begin
                     lastPktSamples = pktSamples;
                     lastEopData    = st_data;
                     lastSopEop     = st_sop;
                  end
                  void'(expQ.pop_front());
               end
            end
         end
         pushW = bus_en && bus_ready;
         if (pushW) begin
            if (wordQ.size() > 0) void'(wordQ.pop_front());
            wordsAccepted++;
         end
         mOcc = mOcc + int'(pushW) - int'(popW);
         if (!bus_ready) sawFull = 1'b1;
         prevStall = st_valid && !st_ready;
         prevData  = st_data;
         prevSop   = st_sop;
         prevEop   = st_eop;
         decPrev   = dec_done;
      end
   end

   initial begin
      int n;
      int lens[3];
      rst         = 1'b1;
      cfg_pkt_len = '0;
      dec_done    = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("reset_bus_ready", {63'd0, bus_ready}, 64'd1);
      checkOutput("reset_valid", {63'd0, st_valid}, 64'd0);
      checkOutput("reset_data", {52'd0, st_data}, 64'd0);
      checkOutput("reset_sop_eop", {62'd0, st_sop, st_eop}, 64'd0);
      checkOutput("reset_credits", {61'd0, credits}, 64'd2);
      checkOutput("reset_err", {63'd0, err_credit}, 64'd0);

      // Basic 1028-sample packet with a sequential sample pattern
      $display("[TB] basic packet");
      cfg_pkt_len   = LEN_W'(1028);
      wordsAccepted = 0;
      applyStimulus(1028, 1, 1'b1);
      n = 0;
      while (!(st_valid && st_sop) && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) noteTimeout("first_sop");
      checkOutput("credits_after_start", {61'd0, credits}, 64'd1);
      waitDrain(5000);
      checkOutput("basic_len", 64'(lastPktSamples), 64'd1028);
      checkOutput("basic_first", {52'd0, firstSopData}, 64'd0);
      checkOutput("basic_last", {52'd0, lastEopData}, 64'd1027);
      checkOutput("basic_words", 64'(wordsAccepted), 64'd25);
      returnCredits();

      // Length boundaries: 1, 0 (treated as 1), one full word
      $display("[TB] boundaries");
      lens[0] = 1; lens[1] = 0; lens[2] = 42;
      for (int i = 0; i < 3; i++) begin
         cfg_pkt_len   = LEN_W'(lens[i]);
         wordsAccepted = 0;
         applyStimulus(lens[i], 1, 1'b0);
         waitDrain(500);
         checkOutput("bound_len", 64'(lastPktSamples), (lens[i] == 42) ? 64'd42 : 64'd1);
         checkOutput("bound_sop_eop", {63'd0, lastSopEop}, (lens[i] == 42) ? 64'd0 : 64'd1);
         checkOutput("bound_words", 64'(wordsAccepted), 64'd1);
         returnCredits();
      end

      // Credit block: third packet must wait until a credit comes back
      $display("[TB] credit block");
      cfg_pkt_len = LEN_W'(84);
      applyStimulus(84, 3, 1'b0);
      n = 0;
      while (expQ.size() > 84 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) noteTimeout("two_packets");
      repeat (5) @(negedge clk);
      checkOutput("blocked_credits", {61'd0, credits}, 64'd0);
      checkOutput("blocked_valid", {63'd0, st_valid}, 64'd0);
      // Second pulse lands on the packet-start edge, leaving the count at 1
      @(posedge clk); #1 dec_done = 1'b1;
      @(posedge clk); #1 dec_done = 1'b1;
      @(posedge clk); #1 dec_done = 1'b0;
      @(negedge clk);
      checkOutput("third_sop", {62'd0, st_valid, st_sop}, 64'd3);
      checkOutput("simul_credits", {61'd0, credits}, 64'd1);
      waitDrain(1000);
      pulseDone();
      pulseDone();
      @(negedge clk);
      checkOutput("err_set", {63'd0, err_credit}, 64'd1);
      checkOutput("err_credits", {61'd0, credits}, 64'd2);
      repeat (5) @(negedge clk);
      checkOutput("err_sticky", {63'd0, err_credit}, 64'd1);

      // Backpressure and bus gaps on the basic pattern
      $display("[TB] backpressure");
      readyPct    = 50;
      gapPct      = 50;
      sawFull     = 1'b0;
      cfg_pkt_len = LEN_W'(1028);
      applyStimulus(1028, 1, 1'b1);
      waitDrain(8000);
      checkOutput("bp_len", 64'(lastPktSamples), 64'd1028);
      checkOutput("bp_first", {52'd0, firstSopData}, 64'd0);
      checkOutput("bp_last", {52'd0, lastEopData}, 64'd1027);
      checkOutput("bp_full", {63'd0, sawFull}, 64'd1);
      returnCredits();

      // Random lengths and data
      $display("[TB] random packets");
      for (int i = 0; i < 4; i++) begin
         n = $urandom_range(200, 1);
         cfg_pkt_len = LEN_W'(n);
         applyStimulus(n, $urandom_range(2, 1), 1'b0);
         waitDrain(4000);
         returnCredits();
      end

      // Reset in the middle of a packet
      $display("[TB] reset mid-packet");
      readyPct    = 100;
      gapPct      = 0;
      pktSamples  = 0;
      cfg_pkt_len = LEN_W'(1028);
      applyStimulus(1028, 1, 1'b1);
      n = 0;
      while (pktSamples < 500 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) noteTimeout("mid_packet");
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_valid", {63'd0, st_valid}, 64'd0);
      checkOutput("rst_credits", {61'd0, credits}, 64'd2);
      checkOutput("rst_bus_ready", {63'd0, bus_ready}, 64'd1);
      checkOutput("rst_err", {63'd0, err_credit}, 64'd0);
      cfg_pkt_len = LEN_W'(100);
      applyStimulus(100, 1, 1'b1);
      waitDrain(1000);
      checkOutput("fresh_first", {52'd0, firstSopData}, 64'd0);
      checkOutput("fresh_len", 64'(lastPktSamples), 64'd100);
      checkOutput("fresh_last", {52'd0, lastEopData}, 64'd99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
